// File: rtl/csr_counter_bank.sv
// csr_counter_bank: RISC-V mcycle/minstret/mhpm counters, prescaled mtime with timer compares,
// counter inhibit/enable CSRs and privilege-checked user read aliases.
module csr_counter_bank #(
   parameter int NUM_HPM  = 4,
   parameter int CNT_W    = 64,
   parameter int TIME_DIV = 1
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               csr_re,
   input  logic [11:0]        csr_addr_r,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr_wb,
   input  logic [31:0]        csr_wdata,
   input  logic [1:0]         priv_mode,
   input  logic               instr_retired,
   input  logic [NUM_HPM-1:0] hpm_event,
   output logic [31:0]        csr_rdata,
   output logic               csr_hit,
   output logic               csr_illegal,
   output logic               timer_irq_m,
   output logic               timer_irq_s
);
   localparam int NC = 3 + NUM_HPM;

   // slot 1 is mtime: same counter datapath, event = prescaler tick, never inhibited or written
   logic [CNT_W-1:0] cnt_q [NC];
   logic [CNT_W-1:0] cnt_d [NC];
   logic [CNT_W-1:0] mtimecmp_q, mtimecmp_d, stimecmp_q, stimecmp_d;
   logic [CNT_W-1:0] rd_arr [32];
   logic [CNT_W-1:0] cv;
   logic [31:0]      pre_q, pre_d, cval, rval, mcen_x, scen_x;
   logic [NC-1:0]    inh_q, inh_d, mcen_q, mcen_d, scen_q, scen_d, ev;
   logic [4:0]       n;
   logic             irq_m_q, irq_s_q, tick, is_b, is_c, c_hit, c_viol, m_mode, s_mode, hit, viol;

   function automatic logic [CNT_W-1:0] wr(input logic [CNT_W-1:0] v, input logic lo, input logic hi,
                                           input logic [31:0] d);
      return lo ? {v[CNT_W-1:32], d} : hi ? {d[CNT_W-33:0], v[31:0]} : v;
   endfunction

   assign tick  = pre_q == 32'(TIME_DIV - 1);
   assign pre_d = tick ? '0 : pre_q + 32'd1;
   assign ev    = {hpm_event, instr_retired, tick, 1'b1};

   for (genvar i = 0; i < NC; i++) begin : g_cnt
      logic lo, hi;
      assign lo = i != 1 && csr_we && csr_addr_wb == 12'hB00 + 12'(i);
      assign hi = i != 1 && csr_we && csr_addr_wb == 12'hB80 + 12'(i);
      assign cnt_d[i] = (lo || hi) ? wr(cnt_q[i], lo, hi, csr_wdata) : cnt_q[i] + CNT_W'(ev[i] & ~inh_q[i]);
   end

   assign inh_d      = (csr_we && csr_addr_wb == 12'h320) ? csr_wdata[NC-1:0] & ~NC'(2) : inh_q;
   assign mcen_d     = (csr_we && csr_addr_wb == 12'h306) ? csr_wdata[NC-1:0] : mcen_q;
   assign scen_d     = (csr_we && csr_addr_wb == 12'h106) ? csr_wdata[NC-1:0] : scen_q;
   assign mtimecmp_d = wr(mtimecmp_q, csr_we && csr_addr_wb == 12'h7C0, csr_we && csr_addr_wb == 12'h7C1, csr_wdata);
   assign stimecmp_d = wr(stimecmp_q, csr_we && csr_addr_wb == 12'h14D, csr_we && csr_addr_wb == 12'h15D, csr_wdata);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
         mtimecmp_q <= '1;
         stimecmp_q <= '1;
         pre_q      <= '0;
         inh_q      <= '0;
         mcen_q     <= '0;
         scen_q     <= '0;
         irq_m_q    <= 1'b0;
         irq_s_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mtimecmp_q <= mtimecmp_d;
         stimecmp_q <= stimecmp_d;
         pre_q      <= pre_d;
         inh_q      <= inh_d;
         mcen_q     <= mcen_d;
         scen_q     <= scen_d;
         irq_m_q    <= cnt_q[1] >= mtimecmp_q;
         irq_s_q    <= cnt_q[1] >= stimecmp_q;
      end
   end

   for (genvar i = 0; i < 32; i++) begin : g_rd
      if (i < NC) begin : g_impl
         assign rd_arr[i] = cnt_q[i];
      end else begin : g_zero
         assign rd_arr[i] = '0;
      end
   end

   assign n      = csr_addr_r[4:0];
   assign is_b   = csr_addr_r[11:8] == 4'hB;
   assign is_c   = csr_addr_r[11:8] == 4'hC;
   assign c_hit  = (is_b || is_c) && csr_addr_r[6:5] == 2'b00 && !(is_b && n == 5'd1);
   assign cv     = rd_arr[n];
   assign cval   = csr_addr_r[7] ? 32'(cv[CNT_W-1:32]) : cv[31:0];
   assign m_mode = priv_mode == 2'b11;
   assign s_mode = priv_mode == 2'b01;
   assign mcen_x = 32'(mcen_q);
   assign scen_x = 32'(scen_q);
   assign c_viol = !m_mode && !(mcen_x[n] && (s_mode || scen_x[n]));

   always_comb begin
      hit  = 1'b1;
      viol = !m_mode;
      rval = '0;
      case (csr_addr_r)
         12'h320: rval = 32'(inh_q);
         12'h306: rval = mcen_x;
         12'h106: begin rval = scen_x; viol = !m_mode && !s_mode; end
         12'h7C0: rval = mtimecmp_q[31:0];
         12'h7C1: rval = 32'(mtimecmp_q[CNT_W-1:32]);
         12'h14D: begin rval = stimecmp_q[31:0]; viol = !m_mode && !s_mode; end
         12'h15D: begin rval = 32'(stimecmp_q[CNT_W-1:32]); viol = !m_mode && !s_mode; end
         default: begin hit = c_hit; rval = cval; viol = is_c ? c_viol : !m_mode; end
      endcase
   end

   assign csr_hit     = hit;
   assign csr_rdata   = hit ? rval : '0;
   assign csr_illegal = csr_re & hit & viol;
   assign timer_irq_m = irq_m_q;
   assign timer_irq_s = irq_s_q;
endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed scoreboard bench; a behavioural model tracks counters, mtime,
// compares and enables, and expected values are queued before each DUT sample.
module tb_csr_counter_bank;
   logic        clk = 1'b0, nrst = 1'b0, csr_re = 1'b0, csr_we = 1'b0, instr_retired = 1'b0;
   logic [11:0] csr_addr_r = '0, csr_addr_wb = '0;
   logic [31:0] csr_wdata = '0;
   logic [1:0]  priv_mode = 2'b11;
   logic [3:0]  hpm_event = '0;
   logic [31:0] csr_rdata;
   logic        csr_hit, csr_illegal, timer_irq_m, timer_irq_s;

   always #50 clk = ~clk;

   csr_counter_bank #(.NUM_HPM(4), .CNT_W(64), .TIME_DIV(4)) dut (
      .clk(clk), .nrst(nrst), .csr_re(csr_re), .csr_addr_r(csr_addr_r), .csr_we(csr_we),
      .csr_addr_wb(csr_addr_wb), .csr_wdata(csr_wdata), .priv_mode(priv_mode),
      .instr_retired(instr_retired), .hpm_event(hpm_event), .csr_rdata(csr_rdata),
      .csr_hit(csr_hit), .csr_illegal(csr_illegal), .timer_irq_m(timer_irq_m), .timer_irq_s(timer_irq_s)
   );

   int          n_chk = 0, n_err = 0, cycles = 0, m_pre;
   logic [63:0] exp_q [$];
   string       tag_q [$];
   logic [63:0] m_cnt [7];
   logic [63:0] m_time, m_mcmp, m_scmp;
   logic [6:0]  m_inh, m_mcen, m_scen;
   logic        m_irqm, m_irqs;

   task automatic m_reset();
      for (int i = 0; i < 7; i++) m_cnt[i] = '0;
      m_time = '0; m_pre = 0; m_mcmp = '1; m_scmp = '1;
      m_inh = '0; m_mcen = '0; m_scen = '0; m_irqm = 1'b0; m_irqs = 1'b0; cycles = 0;
   endtask

   // one clock: model advances from the inputs held across the coming rising edge
   task automatic cyc();
      logic [6:0] ev;
      logic irqm_n, irqs_n;
      irqm_n = m_time >= m_mcmp;
      irqs_n = m_time >= m_scmp;
      ev = {hpm_event, instr_retired, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) if (i != 1) begin
         if (csr_we && csr_addr_wb == 12'hB00 + 12'(i)) m_cnt[i][31:0] = csr_wdata;
         else if (csr_we && csr_addr_wb == 12'hB80 + 12'(i)) m_cnt[i][63:32] = csr_wdata;
         else if (ev[i] && !m_inh[i]) m_cnt[i] = m_cnt[i] + 64'd1;
      end
      if (csr_we) case (csr_addr_wb)
         12'h320: m_inh = csr_wdata[6:0] & 7'h7D;
         12'h306: m_mcen = csr_wdata[6:0];
         12'h106: m_scen = csr_wdata[6:0];
         12'h7C0: m_mcmp[31:0] = csr_wdata;
         12'h7C1: m_mcmp[63:32] = csr_wdata;
         12'h14D: m_scmp[31:0] = csr_wdata;
         12'h15D: m_scmp[63:32] = csr_wdata;
         default: ;
      endcase
      if (m_pre == 3) begin m_time = m_time + 64'd1; m_pre = 0; end else m_pre = m_pre + 1;
      m_irqm = irqm_n;
      m_irqs = irqs_n;
      cycles = cycles + 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] mread(input logic [11:0] a);
      if (a == 12'hC01) return m_time[31:0];
      if (a == 12'hC81) return m_time[63:32];
      for (int i = 0; i < 7; i++) if (i != 1) begin
         if (a == 12'hB00 + 12'(i) || a == 12'hC00 + 12'(i)) return m_cnt[i][31:0];
         if (a == 12'hB80 + 12'(i) || a == 12'hC80 + 12'(i)) return m_cnt[i][63:32];
      end
      case (a)
         12'h320: return 32'(m_inh);
         12'h306: return 32'(m_mcen);
         12'h106: return 32'(m_scen);
         12'h7C0: return m_mcmp[31:0];
         12'h7C1: return m_mcmp[63:32];
         default: return '0;
      endcase
   endfunction

   task automatic push(input string t, input logic [63:0] e);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      logic [63:0] e;
      string t;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
   endtask

   // sel: 0 rdata, 1 illegal, 2 hit, 3 irq_m, 4 irq_s
   task automatic obs_chk(input int sel);
      logic [63:0] o;
      o = sel == 0 ? 64'(csr_rdata) : sel == 1 ? 64'(csr_illegal) : sel == 2 ? 64'(csr_hit) :
          sel == 3 ? 64'(timer_irq_m) : 64'(timer_irq_s);
      pop_chk(o);
   endtask

   task automatic rd(input logic [11:0] a, input string t, input logic [63:0] e);
      csr_addr_r = a;
      push(t, e);
      #1;
      obs_chk(0);
   endtask

   task automatic flag(input int sel, input string t, input logic e);
      push(t, 64'(e));
      #1;
      obs_chk(sel);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we = 1'b1; csr_addr_wb = a; csr_wdata = d;
      cyc();
      csr_we = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      @(negedge clk);
      csr_re = 1'b1;
      rd(12'hB00, "rst_mcycle", 0);
      flag(3, "rst_irqm", 1'b0);
      flag(4, "rst_irqs", 1'b0);
      rd(12'h7C0, "rst_mtimecmp", 64'hFFFF_FFFF);
      nrst = 1'b1;
      repeat (10) cyc();
      rd(12'hB00, "idle_mcycle", 10);
      rd(12'hB02, "idle_minstret", 0);
      rd(12'hC01, "idle_mtime", 2);
      flag(3, "idle_irqm", 1'b0);

      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      rd(12'hB00, "wr_lo_hold", 64'hFFFF_FFFF);
      rd(12'hB80, "wr_hi", 0);
      cyc();
      rd(12'hB80, "carry_hi", 1);
      rd(12'hB00, "carry_lo", 0);
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'hFFFF_FFFF);
      rd(12'hB80, "max_hi", 64'hFFFF_FFFF);
      cyc();
      rd(12'hB00, "wrap_lo", 0);
      rd(12'hB80, "wrap_hi", 0);

      wr(12'h320, 32'h5);
      rd(12'h320, "inh_rd", 5);
      instr_retired = 1'b1;
      repeat (3) cyc();
      instr_retired = 1'b0;
      rd(12'hB00, "inh_mcycle", 1);
      rd(12'hB02, "inh_minstret", 0);
      wr(12'h320, 32'hFFFF_FFFF);
      rd(12'h320, "inh_mask", 64'h7D);
      wr(12'h320, 32'h0);
      rd(12'hB00, "inh_old_val", 1);
      cyc();
      rd(12'hB00, "resume_mcycle", 2);
      hpm_event = 4'b0001;
      repeat (4) cyc();
      hpm_event = 4'b0000;
      rd(12'hB03, "hpm3", 4);
      rd(12'hB83, "hpm3_hi", 0);
      instr_retired = 1'b1;
      repeat (2) cyc();
      instr_retired = 1'b0;
      rd(12'hB02, "minstret", 2);
      rd(12'hC02, "instret_alias", 2);
      rd(12'hB00, "mcycle_model", 64'(mread(12'hB00)));

      nrst = 1'b0;
      m_reset();
      rd(12'hB03, "areset_hpm3", 0);
      nrst = 1'b1;
      wr(12'h7C0, 32'd5);
      wr(12'h7C1, 32'd0);
      for (int i = 0; i < 40 && !timer_irq_m; i++) begin
         cyc();
         flag(3, "irqm_trace", m_irqm);
      end
      flag(3, "irqm_rise", 1'b1);
      rd(12'hC01, "mtime_at_irq", 5);
      push("irq_cycle", 21);
      pop_chk(64'(cycles));
      wr(12'h7C0, 32'd100);
      flag(3, "irqm_hold", 1'b1);
      cyc();
      flag(3, "irqm_drop", 1'b0);
      wr(12'h14D, 32'd3);
      wr(12'h15D, 32'd0);
      flag(4, "irqs_pre", 1'b0);
      cyc();
      flag(4, "irqs_rise", 1'b1);

      priv_mode = 2'b00;
      wr(12'h306, 32'h1);
      wr(12'h106, 32'h0);
      rd(12'hC00, "u_data", 64'(mread(12'hC00)));
      flag(1, "u_no_scen", 1'b1);
      wr(12'h106, 32'h1);
      rd(12'hC00, "u_ok_data", 64'(mread(12'hC00)));
      flag(1, "u_ok", 1'b0);
      rd(12'hC01, "u_time_data", 64'(mread(12'hC01)));
      flag(1, "u_time_ill", 1'b1);
      rd(12'h106, "u_scen_data", 1);
      flag(1, "u_scen_ill", 1'b1);
      priv_mode = 2'b01;
      rd(12'h106, "s_scen_data", 1);
      flag(1, "s_scen_ok", 1'b0);
      rd(12'hC00, "s_cycle_data", 64'(mread(12'hC00)));
      flag(1, "s_cycle_ok", 1'b0);
      rd(12'hC01, "s_time_data", 64'(mread(12'hC01)));
      flag(1, "s_time_ill", 1'b1);
      rd(12'hB00, "s_mcycle_data", 64'(mread(12'hB00)));
      flag(1, "s_mcycle_ill", 1'b1);
      csr_re = 1'b0;
      flag(1, "no_re", 1'b0);
      flag(2, "no_re_hit", 1'b1);
      priv_mode = 2'b11;
      csr_re = 1'b1;
      rd(12'hB1F, "unimp_data", 0);
      flag(2, "unimp_hit", 1'b1);
      flag(1, "unimp_ill", 1'b0);
      rd(12'hB01, "b01_data", 0);
      flag(2, "b01_hit", 1'b0);

      wr(12'h7C0, 32'd0);
      cyc();
      flag(3, "irqm_set", 1'b1);
      flag(4, "irqs_set", 1'b1);
      instr_retired = 1'b1;
      hpm_event = 4'b0010;
      repeat (3) cyc();
      instr_retired = 1'b0;
      hpm_event = 4'b0000;
      rd(12'hB04, "hpm4", 3);
      rd(12'hB02, "minstret_pre", 64'(mread(12'hB02)));
      #10;
      nrst = 1'b0;
      m_reset();
      flag(3, "areset_irqm", 1'b0);
      flag(4, "areset_irqs", 1'b0);
      rd(12'hB00, "areset_mcycle", 0);
      rd(12'hB02, "areset_minstret", 0);
      rd(12'hB04, "areset_hpm4", 0);
      rd(12'hC01, "areset_mtime", 0);
      rd(12'h7C0, "areset_mtimecmp", 64'hFFFF_FFFF);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
- Parametrised RISC-V counter/timer CSR bank that sits beside the main CSR register file in the execute/writeback path.
- Implements:
  - mcycle, minstret and NUM_HPM mhpmcounters (CNT_W-bit, 32-bit low/high access).
  - A prescaled mtime, with mtimecmp/stimecmp compare and registered M/S timer interrupts.
  - mcountinhibit, mcounteren and scounteren, with privilege-checked user-level read aliases.
- The CSR file muxes csr_rdata in whenever csr_hit is 1 and raises I_ILLEGAL whenever csr_illegal is 1.

Parameters:
- NUM_HPM, 4, number of implemented mhpmcounters (3..3+NUM_HPM-1); legal 0..29.
- CNT_W, 64, width of every counter; legal 33..64. Bits at or above CNT_W read 0 and ignore writes.
- TIME_DIV, 1, mtime increments once every TIME_DIV clk cycles; legal >=1.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- csr_re  in  1  read/access strobe for csr_addr_r.
- csr_addr_r  in  12  read address.
- csr_we  in  1  write strobe for csr_addr_wb.
- csr_addr_wb  in  12  write address.
- csr_wdata  in  32  write data.
- priv_mode  in  2  current privilege: 00 U, 01 S, 11 M.
- instr_retired  in  1  one instruction retired this cycle.
- hpm_event  in  NUM_HPM  per-counter event pulse; bit i drives mhpmcounter(3+i).
- csr_rdata  out  32  combinational read data.
- csr_hit  out  1  csr_addr_r decodes to a register owned by this block.
- csr_illegal  out  1  csr_re with a privilege/counteren violation on csr_addr_r.
- timer_irq_m  out  1  registered machine timer pending.
- timer_irq_s  out  1  registered supervisor timer pending.

Behaviour:
- Address map:
  - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; 0xB03+k / 0xB83+k mhpmcounter(3+k) for k=0..28.
  - 0xC00/0xC80 cycle; 0xC01/0xC81 time; 0xC02/0xC82 instret; 0xC03+k / 0xC83+k hpmcounter.
  - 0x320 mcountinhibit; 0x306 mcounteren; 0x106 scounteren.
  - 0x7C0/0x7C1 mtimecmp lo/hi; 0x14D/0x15D stimecmp lo/hi.
- Reset values:
  - All counters, mtime, mcountinhibit, mcounteren, scounteren and the prescaler = 0.
  - mtimecmp and stimecmp = all ones, so no interrupt fires after reset.
  - timer_irq_m = 0 and timer_irq_s = 0.
- Counting, evaluated every cycle:
  - mcycle increments unless mcountinhibit[0] = 1.
  - minstret increments when instr_retired=1 and mcountinhibit[2]=0.
  - hpm k increments when hpm_event[k]=1 and mcountinhibit[3+k]=0.
  - All counters wrap from 2^CNT_W-1 to 0.
  - mcountinhibit[1] is hardwired 0; bits above 2+NUM_HPM are hardwired 0.
- mtime:
  - The prescaler counts 0..TIME_DIV-1; mtime increments when the prescaler reaches TIME_DIV-1, and the prescaler then returns to 0.
  - mtime is not inhibitable and is writable only via the cycle-accurate reset.
- Writes (csr_we):
  - Low-half write replaces bits 31:0; high-half write replaces bits CNT_W-1:32. The other half holds.
  - A write takes precedence over the increment in the same cycle, and no carry is propagated that cycle.
  - Written value is visible on the next cycle.
  - Writes to 0xC** addresses, to unimplemented hpm indices and to time are ignored.
  - mcounteren/scounteren store bits [2+NUM_HPM:0].
- Reads, combinational:
  - Unimplemented hpm addresses still hit and return 0.
  - For CNT_W<64, the high half returns zero-extended bits.
  - csr_rdata = 0 when csr_hit = 0.
- Access check for 0xC** reads (bit n = addr[4:0]):
  - M: always legal.
  - S: legal iff mcounteren[n].
  - U: legal iff mcounteren[n] and scounteren[n].
  - 0xB**, 0x320, 0x306 and 0x7C* from non-M, and 0x1** from U, are illegal.
  - csr_illegal = csr_re & csr_hit & violation; it is 0 when csr_re = 0.
- Timer interrupts:
  - timer_irq_m <= (mtime >= mtimecmp); timer_irq_s <= (mtime >= stimecmp). Unsigned CNT_W compare, one-cycle latency.
  - Writing a compare register updates the irq on the cycle after the new value is visible.
- Simultaneous events:
  - Read and write of the same address in one cycle returns the old value.
  - Inhibit-bit write and event in the same cycle: the event uses the old inhibit value.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous).

Test Plan:
- Reset, then 10 idle cycles, read 0xB00 -> 10 (±pipeline offset fixed at 0); 0xB02 -> 0; timer_irq_m=0.
- Write 0xB00=0xFFFFFFFF and 0xB80=0 (CNT_W=64), wait 1 cycle -> 0xB80 reads 1 and 0xB00 reads 0 (carry across halves). Write 0xB80=0xFFFFFFFF at 0xFFFFFFFF_FFFFFFFF -> wraps to 0.
- Set mcountinhibit=0x5, pulse instr_retired 3× -> mcycle and minstret frozen. Clear the inhibit -> counting resumes; hpm_event[0] ×4 -> 0xB03=4.
- TIME_DIV=4, mtimecmp=5 -> timer_irq_m rises exactly 1 cycle after mtime reaches 5 (cycle 21±prescaler phase). Rewrite mtimecmp=100 -> irq drops the following cycle.
- priv_mode=U, mcounteren=0x1, scounteren=0: csr_re on 0xC00 -> csr_illegal=1. scounteren=0x1 -> csr_illegal=0 with correct data. Read 0xC01 -> illegal.
- Read 0xB1F with NUM_HPM=4 in M -> csr_hit=1, csr_rdata=0, csr_illegal=0. Assert nrst mid-count -> all counters 0 and irqs 0 asynchronously.
